// File: rtl/udma_stream_packer.sv
// Packs byte/halfword/word stream items (LSB lane first) into full words with byte enables.
// A partial word is flushed on end-of-frame or when the next item does not fit.
module udma_stream_packer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [1:0]            in_datasize_i,
    input  logic                  in_valid_i,
    input  logic                  in_sot_i,
    input  logic                  in_eot_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [3:0]            out_be_o,
    output logic                  out_valid_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic [CNT_WIDTH-1:0]  word_cnt_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {StIdle, StPack, StTail} state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   acc_data_q;
    logic [3:0]              acc_be_q;
    logic [1:0]              off_q;
    logic                    tail_last_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [3:0]              out_be_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic [CNT_WIDTH-1:0]    word_cnt_q;
    logic                    err_q;

    logic [2:0]              nbytes;
    logic [3:0]              item_mask;
    logic [DATA_WIDTH-1:0]   item_data;
    logic                    illegal;
    logic                    stale;
    logic [1:0]              base_off;
    logic [DATA_WIDTH-1:0]   base_data;
    logic [3:0]              base_be;
    logic [2:0]              end_off;
    logic                    fit;
    logic                    fill;
    logic [DATA_WIDTH-1:0]   merged_data;
    logic [3:0]              merged_be;
    logic                    slot_free;
    logic                    accept;

    always_comb begin
        nbytes    = 3'd0;
        item_mask = 4'b0000;
        item_data = '0;
        case (in_datasize_i)
            2'b00: begin
                nbytes    = 3'd1;
                item_mask = 4'b0001;
                item_data = DATA_WIDTH'(in_data_i[7:0]);
            end
            2'b01: begin
                nbytes    = 3'd2;
                item_mask = 4'b0011;
                item_data = DATA_WIDTH'(in_data_i[15:0]);
            end
            2'b10: begin
                nbytes    = 3'd4;
                item_mask = 4'b1111;
                item_data = in_data_i;
            end
            default: ;
        endcase
        illegal     = (in_datasize_i == 2'b11);
        // A new frame starting over a half-filled word throws the stale bytes away.
        stale       = in_sot_i && (off_q != 2'd0);
        base_off    = stale ? 2'd0 : off_q;
        base_data   = stale ? '0 : acc_data_q;
        base_be     = stale ? 4'b0000 : acc_be_q;
        end_off     = {1'b0, base_off} + nbytes;
        fit         = (end_off <= 3'd4);
        fill        = (end_off == 3'd4);
        merged_data = base_data | (item_data << {base_off, 3'b000});
        merged_be   = base_be | (item_mask << base_off);
    end

    assign slot_free  = !out_valid_q || out_ready_i;
    assign in_ready_o = slot_free && (state_q != StTail) && !rst_i && !clr_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q     <= StIdle;
            acc_data_q  <= '0;
            acc_be_q    <= 4'b0000;
            off_q       <= 2'd0;
            tail_last_q <= 1'b0;
            out_data_q  <= '0;
            out_be_q    <= 4'b0000;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
                if (word_cnt_q != '1) begin
                    word_cnt_q <= word_cnt_q + 1'b1;
                end
            end
            // Emits below override the out_valid_q clear: the slot reloads in the handshake cycle.
            if (state_q == StTail) begin
                if (slot_free) begin
                    out_data_q  <= acc_data_q;
                    out_be_q    <= acc_be_q;
                    out_last_q  <= tail_last_q;
                    out_valid_q <= 1'b1;
                    acc_data_q  <= '0;
                    acc_be_q    <= 4'b0000;
                    off_q       <= 2'd0;
                    state_q     <= tail_last_q ? StIdle : StPack;
                end
            end else if (accept) begin
                if (illegal) begin
                    err_q <= 1'b1;
                    if (in_eot_i) begin
                        if (acc_be_q != 4'b0000) begin
                            out_data_q  <= acc_data_q;
                            out_be_q    <= acc_be_q;
                            out_last_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                        end
                        acc_data_q <= '0;
                        acc_be_q   <= 4'b0000;
                        off_q      <= 2'd0;
                        state_q    <= StIdle;
                    end else begin
                        state_q <= StPack;
                    end
                end else begin
                    if (stale) begin
                        err_q <= 1'b1;
                    end
                    if (fit) begin
                        if (fill || in_eot_i) begin
                            out_data_q  <= merged_data;
                            out_be_q    <= merged_be;
                            out_last_q  <= in_eot_i;
                            out_valid_q <= 1'b1;
                            acc_data_q  <= '0;
                            acc_be_q    <= 4'b0000;
                            off_q       <= 2'd0;
                            state_q     <= in_eot_i ? StIdle : StPack;
                        end else begin
                            acc_data_q <= merged_data;
                            acc_be_q   <= merged_be;
                            off_q      <= end_off[1:0];
                            state_q    <= StPack;
                        end
                    end else begin
                        // No fit implies no stale discard, so base_* is the live accumulator.
                        out_data_q  <= base_data;
                        out_be_q    <= base_be;
                        out_last_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        acc_data_q  <= item_data;
                        acc_be_q    <= item_mask;
                        off_q       <= nbytes[1:0];
                        if ((nbytes == 3'd4) || in_eot_i) begin
                            tail_last_q <= in_eot_i;
                            state_q     <= StTail;
                        end else begin
                            state_q <= StPack;
                        end
                    end
                end
            end
        end
    end

    assign out_data_o  = out_data_q;
    assign out_be_o    = out_be_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign word_cnt_o  = word_cnt_q;
    assign err_o       = err_q;

endmodule
